mmc1_prg_bank_ctrl: RTL and testbench
=====================================

// Module: mmc1_prg_bank_ctrl
// PURPOSE
//  MMC1 (SxROM) mapper controller that replaces the fixed 32 KB map of the flat PRG ROM mapper.
//  It decodes CPU writes to $8000-$FFFF into the MMC1 serial-load protocol and holds four
//  5-bit config registers: control, CHR bank 0, CHR bank 1 and PRG bank.
//  From these registers it drives the banked PRG ROM address, the CHR bank selects,
//  nametable mirroring and the PRG-RAM enable.
//  Sits between the bus control unit's $8000-$FFFF chip enable and the block-RAM PRG ROM array.
// PARAMETERS
//  PRG_BANK_BITS  4   16 KB PRG bank index width (16 banks = 256 KB); o_prg_addr is 14+PRG_BANK_BITS wide
//  CHR_BANK_BITS  5   4 KB CHR bank index width
// PORTS
//  i_clk_cpu       in   1                CPU clock; one rising edge per CPU bus cycle
//  i_rst_n         in   1                synchronous reset, active-low
//  i_ce            in   1                chip enable from the BCU, asserted for $8000-$FFFF
//  i_rnw           in   1                1 = read, 0 = write
//  i_addr          in   16               full CPU address
//  i_data_in       in   8                CPU write data
//  o_prg_addr      out  14+PRG_BANK_BITS byte address into the PRG ROM array
//  o_chr_bank_lo   out  CHR_BANK_BITS    4 KB bank for PPU $0000-$0FFF
//  o_chr_bank_hi   out  CHR_BANK_BITS    4 KB bank for PPU $1000-$1FFF
//  o_mirroring     out  2                0 = one-screen lower, 1 = one-screen upper, 2 = vertical, 3 = horizontal
//  o_prg_ram_en    out  1                1 = $6000-$7FFF PRG RAM enabled
// BEHAVIOUR
//  Clocking and reset
//  - One clock (i_clk_cpu). Reset is synchronous, active-low, sampled on the rising edge.
//  - Reset values: ctrl = 5'h0C (PRG mode 3, CHR 8 KB mode, mirroring 0); chr0 = 0; chr1 = 0; prg = 0;
//    shift = 5'b10000; wr_prev = 0.
//  - Resulting outputs after reset: o_mirroring = 0, o_prg_ram_en = 1, o_chr_bank_lo = 0, o_chr_bank_hi = 1.
//  Write qualification
//  - wr = i_ce & ~i_rnw.
//  - wr_prev <= wr every cycle.
//  - A wr with wr_prev = 1 is ignored (RMW double-write suppression); the accepted write is the first one.
//  Serial load (accepted writes only)
//  - i_data_in[7] = 1: shift <= 5'b10000; ctrl[3:2] <= 2'b11; other registers unchanged.
//    The load is aborted mid-sequence with no partial commit.
//  - Otherwise with shift[0] = 0: shift <= {i_data_in[0], shift[4:1]}.
//  - Otherwise with shift[0] = 1 (fifth write): val = {i_data_in[0], shift[4:1]}; shift <= 5'b10000.
//    val commits by i_addr[14:13]: 0 -> ctrl, 1 -> chr0, 2 -> chr1, 3 -> prg.
//    The register select uses the address of the fifth write only.
//  - Committed values are visible on the outputs in the cycle after the commit edge.
//  PRG mapping (combinational from i_addr and registers; zero latency)
//  - bank = prg[PRG_BANK_BITS-1:0]; LAST = all-ones.
//  - ctrl[3:2] = 0 or 1: 32 KB mode, o_prg_addr = {bank[MSB:1], i_addr[14:0]} (bank bit 0 ignored).
//  - ctrl[3:2] = 2: $8000 = bank 0, $C000 = bank.
//  - ctrl[3:2] = 3: $8000 = bank, $C000 = LAST.
//  - In 16 KB modes: o_prg_addr = {sel_bank, i_addr[13:0]}.
//  - o_prg_addr depends on i_addr only, not on i_ce or i_rnw; read gating stays in the ROM array.
//  CHR, mirroring and RAM
//  - ctrl[4] = 0 (8 KB mode): lo = {chr0[4:1], 0}, hi = {chr0[4:1], 1}.
//  - ctrl[4] = 1 (4 KB mode): lo = chr0, hi = chr1.
//  - o_mirroring = ctrl[1:0]; o_prg_ram_en = ~prg[4].
//  Boundary cases
//  - Reset asserted mid-load: discards partial shift contents and restores all reset values.
//  - Reset-bit write on the fifth write: reset wins, no commit.
//  - Writes with i_ce = 0 never touch the shift register and do not set wr_prev.
// STRUCTURE
//  - Package mmc1_pkg holds:
//    - register select constants REG_CTRL / REG_CHR0 / REG_CHR1 / REG_PRG;
//    - PRG mode constants PRG_32K, PRG_FIX_FIRST, PRG_FIX_LAST;
//    - reset constants CTRL_RST = 5'h0C and SHIFT_EMPTY = 5'b10000.
//  - One sub-module, mmc1_serial_loader: wr_prev suppression plus the shift register.
//    It outputs a one-cycle commit strobe, a 2-bit select and 5-bit data.
//  - The top level holds the four registers and the combinational PRG/CHR address muxes.
// TESTING
//  - Reset: pull i_rst_n low for 1 cycle -> ctrl = 0C, o_chr_bank_lo/hi = 0/1, o_prg_ram_en = 1.
//    Read $C000 -> o_prg_addr = 0x3C000 (LAST bank).
//  - Five writes to $E000 with data bit0 = 1,0,1,0,0 (idle cycle between each) -> prg = 5'b00101.
//    Read $8123 -> o_prg_addr = 0x14123; $C000 still maps to LAST.
//  - Load 5'b01000 into ctrl via $8000 (PRG mode 2) -> $8000 maps to 0x00000 and $C000 maps to {prg, 14'h0}.
//    Load 5'b00000 (32 KB mode) with prg = 5 -> $8000 maps to 0x10000.
//  - Three serial writes, then a write of 8'h80 -> no commit and shift empty.
//    Five further writes commit normally; ctrl[3:2] reads back 3 after the 8'h80 write.
//  - Two back-to-back write cycles (RMW) -> only the first bit is shifted.
//    Five RMW pairs therefore commit exactly one value.
//  - Load chr0 = 5'h0B, chr1 = 5'h03 in 8 KB mode -> lo/hi = 0A/0B.
//    Switch ctrl[4] = 1 -> lo/hi = 0B/03.
//    Also set ctrl[1:0] = 2 -> o_mirroring = 2.

Source files
------------

// File: rtl/mmc1_pkg.sv
// mmc1_pkg: register select, PRG mode and reset constants shared by the MMC1 PRG bank controller
package mmc1_pkg;
  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHR0 = 2'd1;
  localparam logic [1:0] REG_CHR1 = 2'd2;
  localparam logic [1:0] REG_PRG = 2'd3;
  localparam logic [1:0] PRG_32K = 2'd0;
  localparam logic [1:0] PRG_FIX_FIRST = 2'd2;
  localparam logic [1:0] PRG_FIX_LAST = 2'd3;
  localparam logic [4:0] CTRL_RST = 5'h0C;
  localparam logic [4:0] SHIFT_EMPTY = 5'b10000;
endpackage

// File: rtl/mmc1_prg_bank_ctrl_if.sv
// mmc1_prg_bank_ctrl_if: CPU bus into the mapper (ce for $8000-$FFFF, rnw, 16-bit addr, 8-bit write data)
interface mmc1_prg_bank_ctrl_if;
  logic ce;
  logic rnw;
  logic [15:0] addr;
  logic [7:0] data_in;
  modport master(output ce, rnw, addr, data_in);
  modport slave(input ce, rnw, addr, data_in);
endinterface

// File: rtl/mmc1_serial_loader.sv
// mmc1_serial_loader: RMW-suppressed 5-bit serial load; ports wr/data_in/sel_in in, commit/clear strobes with sel/val out
module mmc1_serial_loader
  import mmc1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr,
  input  logic [7:0] data_in,
  input  logic [1:0] sel_in,
  output logic       commit,
  output logic       clear,
  output logic [1:0] sel,
  output logic [4:0] val
);
  logic wr_prev;
  logic acc;
  logic [4:0] shift;
  always_comb begin
    acc = wr & ~wr_prev;
    clear = acc & data_in[7];
    commit = acc & ~data_in[7] & shift[0];
    sel = sel_in;
    val = {data_in[0], shift[4:1]};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_prev <= 1'b0;
      shift <= SHIFT_EMPTY;
    end else begin
      wr_prev <= wr;
      if (clear || commit) shift <= SHIFT_EMPTY;
      else if (acc) shift <= val;
    end
  end
endmodule

// File: rtl/mmc1_prg_bank_ctrl.sv
// mmc1_prg_bank_ctrl: MMC1 config registers plus PRG/CHR bank muxes; clk/rst_n, CPU bus in, prg addr/chr banks/mirroring/ram enable out
module mmc1_prg_bank_ctrl
  import mmc1_pkg::*;
#(
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5
) (
  input  logic                        i_clk_cpu,
  input  logic                        i_rst_n,
  mmc1_prg_bank_ctrl_if.slave         bus,
  output logic [14+PRG_BANK_BITS-1:0] o_prg_addr,
  output logic [CHR_BANK_BITS-1:0]    o_chr_bank_lo,
  output logic [CHR_BANK_BITS-1:0]    o_chr_bank_hi,
  output logic [1:0]                  o_mirroring,
  output logic                        o_prg_ram_en
);
  logic [4:0] ctrl, chr0, chr1, prg, val;
  logic [1:0] sel, mode;
  logic commit, clear;
  logic [PRG_BANK_BITS-1:0] bank, sel_bank;
  logic [4:0] chr_lo, chr_hi;
  wire unused_ok = &{1'b0, bus.addr[15]};
  mmc1_serial_loader u_loader (
    .clk(i_clk_cpu),
    .rst_n(i_rst_n),
    .wr(bus.ce & ~bus.rnw),
    .data_in(bus.data_in),
    .sel_in(bus.addr[14:13]),
    .commit(commit),
    .clear(clear),
    .sel(sel),
    .val(val)
  );
  always_ff @(posedge i_clk_cpu) begin
    if (!i_rst_n) begin
      ctrl <= CTRL_RST;
      chr0 <= '0;
      chr1 <= '0;
      prg <= '0;
    end else begin
      if (clear) ctrl[3:2] <= 2'b11;
      if (commit && sel == REG_CTRL) ctrl <= val;
      if (commit && sel == REG_CHR0) chr0 <= val;
      if (commit && sel == REG_CHR1) chr1 <= val;
      if (commit && sel == REG_PRG) prg <= val;
    end
  end
  always_comb begin
    mode = ctrl[3:2];
    bank = prg[PRG_BANK_BITS-1:0];
    sel_bank = mode == PRG_FIX_FIRST ? (bus.addr[14] ? bank : '0) : (bus.addr[14] ? '1 : bank);
    o_prg_addr = mode == PRG_FIX_FIRST || mode == PRG_FIX_LAST ? {sel_bank, bus.addr[13:0]}
                                                               : {bank[PRG_BANK_BITS-1:1], bus.addr[14:0]};
    chr_lo = ctrl[4] ? chr0 : {chr0[4:1], 1'b0};
    chr_hi = ctrl[4] ? chr1 : {chr0[4:1], 1'b1};
    o_chr_bank_lo = CHR_BANK_BITS'(chr_lo);
    o_chr_bank_hi = CHR_BANK_BITS'(chr_hi);
    o_mirroring = ctrl[1:0];
    o_prg_ram_en = ~prg[4];
  end
endmodule

// File: tb/tb_mmc1_prg_bank_ctrl.sv
// tb_mmc1_prg_bank_ctrl: directed-vector bench for the MMC1 PRG bank controller
module tb_mmc1_prg_bank_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [17:0] prg_addr;
  logic [4:0] chr_lo, chr_hi;
  logic [1:0] mir;
  logic ram_en;
  int n_cmp = 0;
  int n_bad = 0;
  mmc1_prg_bank_ctrl_if bus ();
  mmc1_prg_bank_ctrl #(.PRG_BANK_BITS(4), .CHR_BANK_BITS(5)) dut (
    .i_clk_cpu(clk),
    .i_rst_n(rst_n),
    .bus(bus),
    .o_prg_addr(prg_addr),
    .o_chr_bank_lo(chr_lo),
    .o_chr_bank_hi(chr_hi),
    .o_mirroring(mir),
    .o_prg_ram_en(ram_en)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic ce, input logic rnw, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.ce = ce;
    bus.rnw = rnw;
    bus.addr = a;
    bus.data_in = d;
  endtask
  task automatic idle();
    cyc(1'b0, 1'b1, 16'h0000, 8'h00);
  endtask
  task automatic load(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, a, {7'b0, v[i]});
      idle();
    end
  endtask
  task automatic rd(input string tag, input logic [15:0] a, input logic [17:0] exp);
    cyc(1'b1, 1'b1, a, 8'h00);
    #1;
    chk(tag, 32'(prg_addr), 32'(exp));
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.ce = 1'b0;
    bus.rnw = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_lo"}, 32'(chr_lo), 32'h00);
    chk({tag, "_hi"}, 32'(chr_hi), 32'h01);
    chk({tag, "_ram"}, 32'(ram_en), 32'h1);
    chk({tag, "_mir"}, 32'(mir), 32'h0);
    rd({tag, "_c000"}, 16'hC000, 18'h3C000);
  endtask
  initial begin
    bus.ce = 1'b0;
    bus.rnw = 1'b1;
    bus.addr = 16'h0000;
    bus.data_in = 8'h00;
    do_reset();
    chk_reset("rst");
    load(16'hE000, 5'b00101);
    rd("prg5_8123", 16'h8123, 18'h14123);
    rd("prg5_c000", 16'hC000, 18'h3C000);
    load(16'h8000, 5'b01000);
    rd("mode2_8000", 16'h8000, 18'h00000);
    rd("mode2_c000", 16'hC000, 18'h14000);
    load(16'h8000, 5'b00000);
    rd("mode0_8000", 16'h8000, 18'h10000);
    rd("mode0_c000", 16'hC000, 18'h14000);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0, 16'h8000, 8'h01);
      idle();
    end
    cyc(1'b1, 1'b0, 16'h8000, 8'h80);
    idle();
    rd("abort_c000", 16'hC000, 18'h3C000);
    chk("abort_mir", 32'(mir), 32'h0);
    load(16'h8000, 5'b01101);
    chk("after_abort_mir", 32'(mir), 32'h1);
    rd("after_abort_c000", 16'hC000, 18'h3C000);
    for (int i = 0; i < 5; i++) begin
      logic [4:0] v;
      v = 5'h0B;
      cyc(1'b1, 1'b0, 16'hA000, {7'b0, v[i]});
      cyc(1'b1, 1'b0, 16'hA000, {7'b0, ~v[i]});
      idle();
    end
    #1;
    chk("rmw_lo", 32'(chr_lo), 32'h0A);
    chk("rmw_hi", 32'(chr_hi), 32'h0B);
    load(16'hC000, 5'h03);
    load(16'h8000, 5'b11110);
    chk("chr4k_lo", 32'(chr_lo), 32'h0B);
    chk("chr4k_hi", 32'(chr_hi), 32'h03);
    chk("mir_vert", 32'(mir), 32'h2);
    load(16'hE000, 5'h15);
    chk("ram_off", 32'(ram_en), 32'h0);
    rd("prg15_8000", 16'h8000, 18'h14000);
    for (int i = 0; i < 5; i++) begin
      logic [4:0] v;
      v = 5'h06;
      cyc(1'b1, 1'b0, 16'hE000, {7'b0, v[i]});
      cyc(1'b0, 1'b0, 16'hE000, {7'b0, ~v[i]});
    end
    idle();
    #1;
    chk("ce0_ram", 32'(ram_en), 32'h1);
    rd("ce0_8000", 16'h8000, 18'h18000);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'hE000, 8'h01);
      idle();
    end
    cyc(1'b1, 1'b0, 16'hE000, 8'h81);
    idle();
    rd("rst5_8000", 16'h8000, 18'h18000);
    load(16'hE000, 5'h01);
    rd("post_rst5_8000", 16'h8000, 18'h04000);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b0, 16'hE000, 8'h01);
      idle();
    end
    do_reset();
    chk_reset("midrst");
    load(16'hE000, 5'h03);
    rd("midrst_8000", 16'h8000, 18'h0C000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
